axi4_data_split_wr: RTL and testbench

//  Write-path AXI4 width down-converter: a wide AXI4 write master (ISIZE data) drives a slim AXI4 slave (OSIZE data).

---
 rtl/axi4_data_split_wr_pkg.sv | 20 ++
 rtl/axi4_data_split_wr_if.sv | 44 ++++
 rtl/axi4_data_split_wr_width_split_verb.sv | 56 +++++
 rtl/axi4_data_split_wr.sv | 91 +++++++++
 tb/tb_axi4_data_split_wr.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/axi4_data_split_wr_pkg.sv
// axi4_data_split_wr_pkg: shared types and width helpers for the wide-to-slim write converter
package axi4_data_split_wr_pkg;
  typedef struct packed {
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
  } aw_attr_t;
  function automatic int clog2_f(input int v);
    for (int r = 0; r < 32; r++) if ((1 << r) >= v) return r;
    return 32;
  endfunction
  function automatic int nsize_f(input int isize, input int osize);
    return isize / osize;
  endfunction
  function automatic int bytes_f(input int bits);
    return bits / 8;
  endfunction
endpackage

// File: rtl/axi4_data_split_wr_if.sv
// axi4_data_split_wr_if: AXI4 write-only port (AW/W/B) with master and slave views
interface axi4_data_split_wr_if #(
  parameter int IDSIZE = 4,
  parameter int ASIZE  = 32,
  parameter int LSIZE  = 8,
  parameter int DSIZE  = 32
);
  logic [IDSIZE-1:0]  aw_id;
  logic [ASIZE-1:0]   aw_addr;
  logic [LSIZE-1:0]   aw_len;
  logic [2:0]         aw_size;
  logic [1:0]         aw_burst;
  logic               aw_lock;
  logic [3:0]         aw_cache;
  logic [2:0]         aw_prot;
  logic [3:0]         aw_qos;
  logic               aw_valid;
  logic               aw_ready;
  logic [DSIZE-1:0]   w_data;
  logic [DSIZE/8-1:0] w_strb;
  logic               w_last;
  logic               w_valid;
  logic               w_ready;
  logic [IDSIZE-1:0]  b_id;
  logic [1:0]         b_resp;
  logic               b_valid;
  logic               b_ready;
  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready
  );
  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready
  );
endinterface

// File: rtl/axi4_data_split_wr_width_split_verb.sv
// width_split_verb: splits each wide stream beat into ISIZE/OSIZE narrow beats, LSB slice first
module width_split_verb
  import axi4_data_split_wr_pkg::*;
#(
  parameter int ISIZE = 256,
  parameter int OSIZE = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ISIZE-1:0]   in_data_i,
  input  logic [ISIZE/8-1:0] in_strb_i,
  input  logic               in_last_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [OSIZE-1:0]   out_data_o,
  output logic [OSIZE/8-1:0] out_strb_o,
  output logic               out_last_o,
  output logic               out_valid_o,
  input  logic               out_ready_i
);
  localparam int NSIZE = nsize_f(ISIZE, OSIZE);
  localparam int OB    = bytes_f(OSIZE);
  localparam int CW    = NSIZE > 1 ? clog2_f(NSIZE) : 1;
  typedef enum logic {EMPTY, HOLD} state_t;
  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [ISIZE-1:0]   data_q;
  logic [ISIZE/8-1:0] strb_q;
  logic               last_q;
  logic               wrap;
  assign wrap        = cnt_q == CW'(NSIZE - 1);
  assign out_valid_o = state_q == HOLD;
  // Reload on the final slice keeps one narrow beat per cycle with no bubble
  assign in_ready_o  = state_q == EMPTY || (wrap && out_ready_i);
  assign out_data_o  = data_q[cnt_q*OSIZE +: OSIZE];
  assign out_strb_o  = strb_q[cnt_q*OB +: OB];
  assign out_last_o  = out_valid_o && last_q && wrap;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      data_q  <= in_data_i;
      strb_q  <= in_strb_i;
      last_q  <= in_last_i;
    end else if (out_valid_o && out_ready_i) begin
      cnt_q <= wrap ? '0 : cnt_q + CW'(1);
      if (wrap) state_q <= EMPTY;
    end
  end
endmodule

// File: rtl/axi4_data_split_wr.sv
// axi4_data_split_wr: AXI4 write-path width down-converter (wide master to slim slave)
module axi4_data_split_wr
  import axi4_data_split_wr_pkg::*;
#(
  parameter int IDSIZE = 4,
  parameter int ASIZE  = 32,
  parameter int ILSIZE = 8,
  parameter int OLSIZE = 8,
  parameter int ISIZE  = 256,
  parameter int OSIZE  = 32
) (
  input logic clk,
  input logic rst,
  axi4_data_split_wr_if.slave  in_bus,
  axi4_data_split_wr_if.master out_bus
);
  localparam int NSIZE = nsize_f(ISIZE, OSIZE);
  logic              aw_full_q;
  logic [IDSIZE-1:0] aw_id_q;
  logic [ASIZE-1:0]  aw_addr_q;
  logic [OLSIZE-1:0] aw_len_q;
  aw_attr_t          aw_attr_q;
  logic [OLSIZE:0]   len_w;
  logic              len_ok;
  logic              b_full_q;
  logic [IDSIZE-1:0] b_id_q;
  logic [1:0]        b_resp_q;
  assign len_w  = (OLSIZE+1)'((32'(in_bus.aw_len) + 32'd1) * 32'(NSIZE) - 32'd1);
  assign len_ok = (32'(in_bus.aw_len) + 32'd1) * 32'(NSIZE) <= (32'd1 << OLSIZE);
  assign in_bus.aw_ready  = !aw_full_q || out_bus.aw_ready;
  assign out_bus.aw_valid = aw_full_q;
  assign out_bus.aw_id    = aw_id_q;
  assign out_bus.aw_addr  = aw_addr_q;
  assign out_bus.aw_len   = aw_len_q;
  assign out_bus.aw_size  = 3'(clog2_f(bytes_f(OSIZE)));
  assign out_bus.aw_burst = aw_attr_q.burst;
  assign out_bus.aw_lock  = aw_attr_q.lock;
  assign out_bus.aw_cache = aw_attr_q.cache;
  assign out_bus.aw_prot  = aw_attr_q.prot;
  assign out_bus.aw_qos   = aw_attr_q.qos;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_full_q <= 1'b0;
      aw_id_q   <= '0;
      aw_addr_q <= '0;
      aw_len_q  <= '0;
      aw_attr_q <= '0;
    end else if (in_bus.aw_valid && in_bus.aw_ready) begin
      aw_full_q <= 1'b1;
      aw_id_q   <= in_bus.aw_id;
      aw_addr_q <= in_bus.aw_addr;
      aw_len_q  <= len_w[OLSIZE-1:0];
      aw_attr_q <= '{in_bus.aw_burst, in_bus.aw_lock, in_bus.aw_cache, in_bus.aw_prot, in_bus.aw_qos};
    end else if (out_bus.aw_ready) begin
      aw_full_q <= 1'b0;
    end
  end
  // A wide burst that cannot be expressed in OLSIZE bits of narrow length is illegal upstream
  assert property (@(posedge clk) disable iff (rst) (in_bus.aw_valid && in_bus.aw_ready) |-> len_ok);
  width_split_verb #(.ISIZE(ISIZE), .OSIZE(OSIZE)) u_split (
    .clk         (clk),
    .rst         (rst),
    .in_data_i   (in_bus.w_data),
    .in_strb_i   (in_bus.w_strb),
    .in_last_i   (in_bus.w_last),
    .in_valid_i  (in_bus.w_valid),
    .in_ready_o  (in_bus.w_ready),
    .out_data_o  (out_bus.w_data),
    .out_strb_o  (out_bus.w_strb),
    .out_last_o  (out_bus.w_last),
    .out_valid_o (out_bus.w_valid),
    .out_ready_i (out_bus.w_ready)
  );
  assign out_bus.b_ready = !b_full_q || in_bus.b_ready;
  assign in_bus.b_valid  = b_full_q;
  assign in_bus.b_id     = b_id_q;
  assign in_bus.b_resp   = b_resp_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_full_q <= 1'b0;
      b_id_q   <= '0;
      b_resp_q <= '0;
    end else if (out_bus.b_valid && out_bus.b_ready) begin
      b_full_q <= 1'b1;
      b_id_q   <= out_bus.b_id;
      b_resp_q <= out_bus.b_resp;
    end else if (in_bus.b_ready) begin
      b_full_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi4_data_split_wr.sv
// tb_axi4_data_split_wr: scoreboard bench for the wide-to-slim AXI4 write converter
module tb_axi4_data_split_wr;
  localparam int N = 8;
  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
    int          idx;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   rnd_en = 1'b0;
  exp_t exp_q[$];
  int   pop_cycles[$];
  axi4_data_split_wr_if #(.IDSIZE(4), .ASIZE(32), .LSIZE(8), .DSIZE(256)) in_if ();
  axi4_data_split_wr_if #(.IDSIZE(4), .ASIZE(32), .LSIZE(8), .DSIZE(32))  out_if ();
  axi4_data_split_wr dut (
    .clk     (clk),
    .rst     (rst),
    .in_bus  (in_if.slave),
    .out_bus (out_if.master)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (rnd_en) out_if.w_ready = 1'($urandom_range(0, 1));
  end
  initial forever begin
    exp_t e;
    @(negedge clk);
    #1;
    if (!rst) begin
      if (out_if.w_valid && in_if.w_ready)
        chk("wrdy_wrap", 64'(exp_q.size() > 0 && exp_q[0].idx == N-1 && out_if.w_ready), 1);
      if (out_if.w_valid && out_if.w_ready) begin
        if (exp_q.size() == 0) chk("w_extra", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("w_data", 64'(out_if.w_data), 64'(e.d));
          chk("w_strb", 64'(out_if.w_strb), 64'(e.s));
          chk("w_last", 64'(out_if.w_last), 64'(e.l));
          pop_cycles.push_back(cyc);
        end
      end
    end
  end
  task automatic send_w(input logic [255:0] d, input logic [31:0] s, input logic l);
    bit ok = 0;
    in_if.w_data  = d;
    in_if.w_strb  = s;
    in_if.w_last  = l;
    in_if.w_valid = 1'b1;
    for (int i = 0; i < N; i++) exp_q.push_back('{d[i*32 +: 32], s[i*4 +: 4], l && i == N-1, i});
    for (int t = 0; t < 200 && !ok; t++) begin
      #1;
      ok = in_if.w_ready;
      @(negedge clk);
    end
    in_if.w_valid = 1'b0;
    if (!ok) chk("w_accept_timeout", 0, 1);
  endtask
  task automatic wait_drain();
    for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 0);
  endtask
  initial begin
    logic [255:0] d;
    in_if.aw_id = '0; in_if.aw_addr = '0; in_if.aw_len = '0; in_if.aw_size = 3'd5;
    in_if.aw_burst = 2'd1; in_if.aw_lock = 1'b0; in_if.aw_cache = '0; in_if.aw_prot = '0;
    in_if.aw_qos = '0; in_if.aw_valid = 1'b0;
    in_if.w_data = '0; in_if.w_strb = '0; in_if.w_last = 1'b0; in_if.w_valid = 1'b0;
    in_if.b_ready = 1'b1;
    out_if.aw_ready = 1'b1; out_if.w_ready = 1'b1;
    out_if.b_id = '0; out_if.b_resp = '0; out_if.b_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_aw_valid", 64'(out_if.aw_valid), 0);
    chk("rst_w_valid", 64'(out_if.w_valid), 0);
    chk("rst_b_valid", 64'(in_if.b_valid), 0);
    chk("rst_aw_ready", 64'(in_if.aw_ready), 1);
    chk("rst_w_ready", 64'(in_if.w_ready), 1);
    chk("rst_b_ready", 64'(out_if.b_ready), 1);
    @(negedge clk);
    in_if.aw_id = 4'd9; in_if.aw_addr = 32'h1000_0040; in_if.aw_len = 8'd3;
    in_if.aw_burst = 2'd1; in_if.aw_cache = 4'h3; in_if.aw_prot = 3'd2; in_if.aw_qos = 4'hA;
    in_if.aw_valid = 1'b1;
    #1;
    chk("aw_pre_valid", 64'(out_if.aw_valid), 0);
    @(negedge clk);
    in_if.aw_valid = 1'b0;
    #1;
    chk("aw_valid", 64'(out_if.aw_valid), 1);
    chk("aw_len", 64'(out_if.aw_len), 31);
    chk("aw_size", 64'(out_if.aw_size), 2);
    chk("aw_addr", 64'(out_if.aw_addr), 64'h1000_0040);
    chk("aw_id", 64'(out_if.aw_id), 9);
    chk("aw_attr", 64'({out_if.aw_burst, out_if.aw_cache, out_if.aw_prot, out_if.aw_qos}), 64'({2'd1, 4'h3, 3'd2, 4'hA}));
    @(negedge clk);
    in_if.aw_len = 8'd0; in_if.aw_valid = 1'b1;
    #1;
    chk("aw_drained", 64'(out_if.aw_valid), 0);
    @(negedge clk);
    in_if.aw_valid = 1'b0;
    #1;
    chk("aw_len0", 64'(out_if.aw_len), 7);
    pop_cycles.delete();
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 32; j++) d[j*8 +: 8] = 8'(k*32 + j);
      send_w(d, '1, k == 3);
    end
    wait_drain();
    chk("t2_beats", 64'(pop_cycles.size()), 32);
    if (pop_cycles.size() == 32) chk("t2_no_gap", 64'(pop_cycles[31] - pop_cycles[0]), 31);
    rnd_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
      send_w(d, $urandom, k % 4 == 3);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain();
    rnd_en = 1'b0;
    @(negedge clk);
    out_if.w_ready = 1'b1;
    pop_cycles.delete();
    for (int j = 0; j < 8; j++) d[j*32 +: 32] = 32'hA0A0_0000 + 32'(j);
    send_w(d, 32'h0000_00FF, 1'b1);
    wait_drain();
    chk("t4_beats", 64'(pop_cycles.size()), 8);
    pop_cycles.delete();
    for (int j = 0; j < 8; j++) d[j*32 +: 32] = 32'hDEAD_0000 + 32'(j);
    send_w(d, '1, 1'b1);
    for (int t = 0; t < 100 && pop_cycles.size() < 3; t++) @(negedge clk);
    chk("t5_pre_pops", 64'(pop_cycles.size()), 3);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t5_w_valid", 64'(out_if.w_valid), 0);
    chk("t5_w_last", 64'(out_if.w_last), 0);
    chk("t5_w_ready", 64'(in_if.w_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    pop_cycles.delete();
    for (int j = 0; j < 8; j++) d[j*32 +: 32] = 32'hBEEF_0000 + 32'(j);
    send_w(d, '1, 1'b1);
    wait_drain();
    chk("t5_beats", 64'(pop_cycles.size()), 8);
    out_if.b_id = 4'd5; out_if.b_resp = 2'd2; out_if.b_valid = 1'b1; in_if.b_ready = 1'b0;
    #1;
    chk("b_ready_empty", 64'(out_if.b_ready), 1);
    @(negedge clk);
    out_if.b_id = 4'd0; out_if.b_resp = 2'd0; out_if.b_valid = 1'b0;
    for (int t = 0; t < 10; t++) begin
      #1;
      chk("b_valid_hold", 64'(in_if.b_valid), 1);
      chk("b_id_hold", 64'(in_if.b_id), 5);
      chk("b_resp_hold", 64'(in_if.b_resp), 2);
      chk("b_ready_full", 64'(out_if.b_ready), 0);
      @(negedge clk);
    end
    in_if.b_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("b_taken", 64'(in_if.b_valid), 0);
    chk("b_ready_after", 64'(out_if.b_ready), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
